// File: rtl/gray_sobel_3x3.sv
// gray_sobel_3x3 -- streaming 3x3 Sobel edge-magnitude stage for 12-bit grey
// pixels on the camera pixel clock. Emits exactly one output pixel per
// accepted input pixel, with a fixed 3-cycle latency independent of gaps.
//
// Ports:
//   iCLK     pixel clock, all logic on the rising edge
//   iRST_N   asynchronous active-low reset
//   iDATA    12-bit grey pixel
//   iDVAL    iDATA valid this cycle (gaps allowed anywhere)
//   iSOF     start of frame, qualified by iDVAL, marks pixel (0,0)
//   iBYPASS  1 = pass iDATA through with the same latency, 0 = Sobel
//   iTHRESH  12-bit binarisation threshold (only with SOBEL_THRESH_EN)
//   oDATA    output pixel, holds while oDVAL=0
//   oDVAL    oDATA valid
//
// Optional feature macro: SOBEL_THRESH_EN -- when defined, adds iTHRESH and
// binarises non-bypass, non-border outputs to 4095/0 against it.
//
// The output for input (x,y) is the Sobel result centred at (x-1,y-1).
// Line-buffer RAM is never cleared; border masking hides stale contents.
module gray_sobel_3x3 #(
   parameter int WIDTH = 640,
   parameter int SHIFT = 2,
   parameter int COL_W = 10
) (
   input  logic        iCLK,
   input  logic        iRST_N,
   input  logic [11:0] iDATA,
   input  logic        iDVAL,
   input  logic        iSOF,
   input  logic        iBYPASS,
`ifdef SOBEL_THRESH_EN
   input  logic [11:0] iTHRESH,
`endif
   output logic [11:0] oDATA,
   output logic        oDVAL
);

   // Zero-extend a pixel into the signed gradient domain.
   function automatic logic signed [14:0] ext15(input logic [11:0] p);
      return $signed({3'b000, p});
   endfunction

   // Magnitude of a 15-bit signed gradient; |v| <= 16380 fits 14 bits.
   function automatic logic [13:0] abs15(input logic signed [14:0] v);
      logic signed [14:0] n;
      n = -v;
      return v[14] ? n[13:0] : v[13:0];
   endfunction

   logic [COL_W-1:0]   col_q, col_d, cur_col_s;
   logic [1:0]         row_q, row_d, cur_row_s;
   logic [11:0]        lb0_mem [0:WIDTH-1];
   logic [11:0]        lb1_mem [0:WIDTH-1];
   logic [11:0]        lb0_rd_s, lb1_rd_s;
   logic [11:0]        win_q [0:2][0:2];
   logic [11:0]        win_d [0:2][0:2];
   logic               v1_q, brd1_q, byp1_q;
   logic [11:0]        dat1_q;
   logic               v2_q, brd2_q, byp2_q;
   logic [11:0]        dat2_q;
   logic signed [14:0] gx_s, gy_s, gx2_q, gy2_q;
   logic [15:0]        mag_s, shf_s;
   logic [11:0]        sat_s, res_s;
   logic [11:0]        odata_q, odata_d;
   logic               odval_q;

   // Position of the current pixel (iSOF overrides) and next-pixel counters.
   always_comb begin
      cur_col_s = col_q;
      cur_row_s = row_q;
      col_d     = col_q;
      row_d     = row_q;
      if (iDVAL) begin
         if (iSOF) begin
            cur_col_s = {COL_W{1'b0}};
            cur_row_s = 2'd0;
         end else begin
            cur_col_s = col_q;
            cur_row_s = row_q;
         end
         if (cur_col_s == COL_W'(WIDTH - 1)) begin
            col_d = {COL_W{1'b0}};
            // Only row<2 matters for border masking, so the row count stops at 2.
            row_d = (cur_row_s == 2'd2) ? 2'd2 : cur_row_s + 2'd1;
         end else begin
            col_d = cur_col_s + COL_W'(1);
            row_d = cur_row_s;
         end
      end else begin
         col_d = col_q;
         row_d = row_q;
      end
   end

   // Column/row counter registers.
   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         col_q <= {COL_W{1'b0}};
         row_q <= 2'd0;
      end else begin
         col_q <= col_d;
         row_q <= row_d;
      end
   end

   // Asynchronous reads return the old contents before this cycle's write.
   assign lb0_rd_s = lb0_mem[cur_col_s];
   assign lb1_rd_s = lb1_mem[cur_col_s];

   // Line buffers: LB0 = previous line, LB1 = the line before it.
   always_ff @(posedge iCLK) begin
      if (iDVAL) begin
         lb1_mem[cur_col_s] <= lb0_rd_s;
         lb0_mem[cur_col_s] <= iDATA;
      end
   end

   // Window shifts left; new right column is {LB1, LB0, iDATA} top to bottom.
   always_comb begin
      win_d = win_q;
      if (iDVAL) begin
         for (int r = 0; r < 3; r++) begin
            win_d[r][0] = win_q[r][1];
            win_d[r][1] = win_q[r][2];
         end
         win_d[0][2] = lb1_rd_s;
         win_d[1][2] = lb0_rd_s;
         win_d[2][2] = iDATA;
      end else begin
         win_d = win_q;
      end
   end

   // S1: window register plus per-pixel border/bypass/data side-band.
   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
               win_q[r][c] <= 12'd0;
            end
         end
         v1_q   <= 1'b0;
         brd1_q <= 1'b0;
         byp1_q <= 1'b0;
         dat1_q <= 12'd0;
      end else begin
         win_q <= win_d;
         v1_q  <= iDVAL;
         if (iDVAL) begin
            brd1_q <= (cur_row_s < 2'd2) || (cur_col_s < COL_W'(2));
            byp1_q <= iBYPASS;
            dat1_q <= iDATA;
         end else begin
            brd1_q <= brd1_q;
            byp1_q <= byp1_q;
            dat1_q <= dat1_q;
         end
      end
   end

   // Horizontal and vertical gradients of the held window.
   assign gx_s = (ext15(win_q[0][2]) + (ext15(win_q[1][2]) <<< 1) + ext15(win_q[2][2]))
               - (ext15(win_q[0][0]) + (ext15(win_q[1][0]) <<< 1) + ext15(win_q[2][0]));
   assign gy_s = (ext15(win_q[2][0]) + (ext15(win_q[2][1]) <<< 1) + ext15(win_q[2][2]))
               - (ext15(win_q[0][0]) + (ext15(win_q[0][1]) <<< 1) + ext15(win_q[0][2]));

   // S2: gradient registers and forwarded side-band.
   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         v2_q   <= 1'b0;
         brd2_q <= 1'b0;
         byp2_q <= 1'b0;
         dat2_q <= 12'd0;
         gx2_q  <= 15'sd0;
         gy2_q  <= 15'sd0;
      end else begin
         v2_q   <= v1_q;
         brd2_q <= brd1_q;
         byp2_q <= byp1_q;
         dat2_q <= dat1_q;
         gx2_q  <= gx_s;
         gy2_q  <= gy_s;
      end
   end

   assign mag_s = {2'b00, abs15(gx2_q)} + {2'b00, abs15(gy2_q)};
   assign shf_s = mag_s >> SHIFT;
   assign sat_s = (shf_s > 16'd4095) ? 12'd4095 : shf_s[11:0];
`ifdef SOBEL_THRESH_EN
   assign res_s = (sat_s >= iTHRESH) ? 12'd4095 : 12'd0;
`else
   assign res_s = sat_s;
`endif

   // S3 output select: bypass wins over border masking; hold when idle.
   always_comb begin
      odata_d = odata_q;
      if (v2_q) begin
         if (byp2_q) begin
            odata_d = dat2_q;
         end else if (brd2_q) begin
            odata_d = 12'd0;
         end else begin
            odata_d = res_s;
         end
      end else begin
         odata_d = odata_q;
      end
   end

   // S3: registered outputs.
   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         odata_q <= 12'd0;
         odval_q <= 1'b0;
      end else begin
         odata_q <= odata_d;
         odval_q <= v2_q;
      end
   end

   assign oDATA = odata_q;
   assign oDVAL = odval_q;

endmodule

// File: tb/tb_gray_sobel_3x3.sv
module tb_gray_sobel_3x3;
   localparam int W     = 640;
   localparam int SHIFT = 2;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b1;
   logic [11:0] data  = 12'd0;
   logic        dval  = 1'b0;
   logic        sof   = 1'b0;
   logic        byp   = 1'b0;
   logic [11:0] th    = 12'd2000;
   logic [11:0] odata;
   logic        odval;

   always #5 clk = ~clk;

   gray_sobel_3x3 #(.WIDTH(W), .SHIFT(SHIFT), .COL_W(10)) dut (
      .iCLK    (clk),
      .iRST_N  (rst_n),
      .iDATA   (data),
      .iDVAL   (dval),
      .iSOF    (sof),
      .iBYPASS (byp),
`ifdef SOBEL_THRESH_EN
      .iTHRESH (th),
`endif
      .oDATA   (odata),
      .oDVAL   (odval)
   );

`ifdef SOBEL_THRESH_EN
   localparam bit THR_EN = 1'b1;
`else
   localparam bit THR_EN = 1'b0;
`endif

   typedef struct {
      int due;
      int val;
      int tag;
   } exp_t;

   exp_t q[$];
   int   cyc      = 0;
   int   errors   = 0;
   int   checks   = 0;
   int   last     = 0;
   bit   mon_en   = 1'b0;
   int   dval_cnt = 0;
   int   tag_mode = 0;
   int   rec_sel  = 0;
   int   cap [0:7];
   int   rec_a[$];
   int   rec_b[$];
   int   img [0:7][0:W-1];
   int   mx = 0;
   int   my = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int absi(input int v);
      return (v < 0) ? -v : v;
   endfunction

   // Sobel magnitude straight from the textbook kernels (centre pixel unused).
   function automatic int sob(input int p00, input int p01, input int p02,
                              input int p10, input int p12,
                              input int p20, input int p21, input int p22,
                              input int thr, input bit thr_en);
      int gx, gy, m;
      gx = (p02 + 2*p12 + p22) - (p00 + 2*p10 + p20);
      gy = (p20 + 2*p21 + p22) - (p00 + 2*p01 + p02);
      m  = (absi(gx) + absi(gy)) >> SHIFT;
      if (m > 4095) m = 4095;
      if (thr_en) m = (m >= thr) ? 4095 : 0;
      return m;
   endfunction

   // Present one accepted pixel and queue what must come out 3 cycles later.
   task automatic send(input int d, input bit s, input bit b);
      int e, tg;
      @(posedge clk); #1;
      data = d[11:0];
      dval = 1'b1;
      sof  = s;
      byp  = b;
      if (s) begin
         mx = 0;
         my = 0;
      end
      if (my < 8) img[my][mx] = d;
      if (b) e = d;
      else if (my < 2 || mx < 2) e = 0;
      else e = sob(img[my-2][mx-2], img[my-2][mx-1], img[my-2][mx],
                   img[my-1][mx-2], img[my-1][mx],
                   img[my][mx-2],   img[my][mx-1],   img[my][mx],
                   int'(th), THR_EN);
      tg = 0;
      if (tag_mode == 1) begin
         if (my == 2 && mx == 320) tg = 1;
         if (my == 2 && mx == 321) tg = 2;
         if (my == 2 && mx == 322) tg = 3;
         if (my == 2 && mx == 100) tg = 4;
         if (my == 3 && mx == 1)   tg = 5;
      end else if (tag_mode == 2) begin
         if (my == 0 && mx == 7)   tg = 6;
      end
      q.push_back('{cyc + 3, e, tg});
      if (mx == W - 1) begin
         mx = 0;
         my++;
      end else begin
         mx++;
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk); #1;
         dval = 1'b0;
         sof  = 1'b1;
         data = 12'($urandom);
         byp  = 1'($urandom);
      end
   endtask

   // Vertical edge: columns < 320 are 0, >= 320 are 4095.
   task automatic edge_frame(input bit gaps, input int rows);
      for (int y = 0; y < rows; y++) begin
         for (int x = 0; x < W; x++) begin
            send((x < 320) ? 0 : 4095, (x == 0 && y == 0), 1'b0);
            if (gaps) idle(2);
         end
      end
      idle(6);
   endtask

   task automatic clear_cap();
      for (int i = 0; i < 8; i++) cap[i] = -1;
   endtask

   // Per-cycle compare against the queued expectations.
   always @(negedge clk) begin
      if (mon_en) begin
         if (odval) dval_cnt++;
         if (!rst_n) begin
            chk("reset_odval", int'(odval), 0);
            chk("reset_odata", int'(odata), 0);
         end else if (q.size() > 0 && q[0].due == cyc) begin
            chk("odval_due", int'(odval), 1);
            chk("odata", int'(odata), q[0].val);
            if (q[0].tag != 0) cap[q[0].tag] = int'(odata);
            if (rec_sel == 1) rec_a.push_back(int'(odata));
            else if (rec_sel == 2) rec_b.push_back(int'(odata));
            last = q[0].val;
            void'(q.pop_front());
         end else begin
            chk("odval_idle", int'(odval), 0);
            chk("odata_hold", int'(odata), last);
         end
      end
   end

   initial begin
      int c0, mism;
      // Power-on reset.
      #2 rst_n = 1'b0;
      #1 mon_en = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      // Hand-computed pins on the reference model.
      chk("model_right_col", sob(0, 0, 100, 0, 100, 0, 0, 100, 0, 1'b0), 100);
      chk("model_top_row",   sob(200, 200, 200, 0, 0, 0, 0, 0, 0, 1'b0), 200);
      chk("model_vedge",     sob(0, 4095, 4095, 0, 4095, 0, 4095, 4095, 0, 1'b0), 4095);
      chk("model_sat",       sob(0, 0, 4095, 0, 4095, 4095, 4095, 4095, 0, 1'b0), 4095);

      // Flat field: 3 lines of 1000.
      c0 = dval_cnt;
      for (int i = 0; i < 3 * W; i++) send(1000, (i == 0), 1'b0);
      idle(6);
      chk("flat_count", dval_cnt - c0, 3 * W);

      // Vertical edge, gap-free. The edge lies between columns 319 and 320,
      // so centres 319 and 320 (inputs x=320,321) straddle it: Gx=16380 -> 4095.
      clear_cap();
      tag_mode = 1;
      rec_sel  = 1;
      edge_frame(1'b0, 5);
      rec_sel  = 0;
      chk("edge_x320", cap[1], 4095);
      chk("edge_x321", cap[2], 4095);
      chk("edge_x322", cap[3], 0);
      chk("edge_far",  cap[4], 0);
      chk("edge_col1", cap[5], 0);
      chk("edge_len",  rec_a.size(), 5 * W);

      // Same image with iDVAL pattern 1,0,0.
      rec_sel = 2;
      edge_frame(1'b1, 5);
      rec_sel = 0;
      chk("gap_seq_len", rec_b.size(), rec_a.size());
      mism = 0;
      for (int i = 0; i < rec_a.size() && i < rec_b.size(); i++)
         if (rec_a[i] != rec_b[i]) mism++;
      chk("gap_seq_eq", mism, 0);

`ifdef SOBEL_THRESH_EN
      clear_cap();
      th = 12'd4095;
      edge_frame(1'b0, 3);
      chk("thr4095_edge", cap[1], 4095);
      chk("thr4095_far",  cap[4], 0);
      th = 12'd2000;
`endif

      // Bypass ramp, border pixels included.
      clear_cap();
      tag_mode = 2;
      for (int i = 0; i < 2 * W; i++) send(i % W, (i == 0), 1'b1);
      idle(6);
      chk("bypass_x7", cap[6], 7);
      tag_mode = 0;

      // Reset in the middle of row 3 at column 100.
      for (int i = 0; i < 3 * W + 100; i++)
         send(((i % W) < 320) ? 0 : 4095, (i == 0), 1'b0);
      @(posedge clk); #1;
      rst_n = 1'b0;
      dval  = 1'b0;
      q.delete();
      last = 0;
      #1;
      chk("rst_imm_odval", int'(odval), 0);
      chk("rst_imm_odata", int'(odata), 0);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      for (int i = 0; i < 3 * W; i++) send($urandom_range(0, 4095), (i == 0), 1'b0);
      idle(6);

      // Short line then a random frame with random gaps and bypass.
      for (int i = 0; i < 100; i++) send($urandom_range(0, 4095), (i == 0), 1'b0);
      for (int i = 0; i < 3 * W; i++) begin
         send($urandom_range(0, 4095), (i == 0), ($urandom_range(0, 7) == 0));
         if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      end
      idle(6);
      chk("queue_drained", q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
